a_trace_ram_wr_ctrl_64: RTL and testbench
=========================================

// Module: a_trace_ram_wr_ctrl_64
// PURPOSE
//  Downstream of the 48-to-64-bit trace optimiser. Takes its compressed words
//  {data[47:0], repeat_cnt[14:0], eq} and their capture strobe, and writes them into a
//  trace RAM. Stops at the almost-full threshold and raises full/overflow flags.
//  Once the run ends, the host reads the words back in write order.
// PARAMETERS
//  AW      13       RAM address width (LENGTH_RAM_TRACE)
//  DEPTH   8192     RAM words (PROF_RAM_TRACE)
//  FULL_T  13'h1FF7 word count at which writing stops (DEPTH-9, FULL_RAM_TRACE)
//  FLUSH   4        cycles still accepted after run_verif_i falls
// PORTS
//  clk_ref     in   1    reference clock, all logic on rising edge
//  rst_n       in   1    asynchronous active-low reset
//  run_verif_i in   1    verification run enable (level)
//  capt_i      in   1    write strobe from optimiser (r_comp_capt_o)
//  data_i      in   64   trace word from optimiser (r_data_o)
//  rd_req_i    in   1    host read request, one word per cycle high
//  rd_data_o   out  64   readback word
//  rd_valid_o  out  1    rd_data_o valid this cycle
//  rd_last_o   out  1    qualifies rd_valid_o: this is the final stored word
//  nb_word_o   out  AW+1 number of stored words
//  full_o      out  1    nb_word_o reached FULL_T
//  ovf_o       out  1    sticky: a capt_i was dropped while full
//  busy_o      out  1    state is RUN or FLUSH
// BEHAVIOUR
//  Reset: all outputs 0. wr_ptr, rd_ptr and state cleared to IDLE. RAM contents not cleared.
//  Run-enable edge: run_verif_i is registered once (r_run); rise = r_run & ~r_run_q.
//  FSM IDLE->RUN on rise. RUN->FLUSH when r_run=0. FLUSH->DONE after FLUSH cycles.
//    DONE->RUN on rise. Reset mid-operation returns to IDLE.
//  Entering RUN: wr_ptr, rd_ptr, nb_word_o, full_o and ovf_o clear in the same cycle.
//  Write path (RUN or FLUSH only): capt_i=1 and !full_o writes data_i at wr_ptr.
//    wr_ptr and nb_word_o increment. capt_i while full_o drops the word and sets ovf_o.
//    capt_i in IDLE/DONE is ignored, no flag.
//  full_o is registered. It rises the cycle after the write that makes nb_word_o==FULL_T,
//    so at most FULL_T words are stored.
//  Read path (DONE only): rd_req_i with rd_ptr<nb_word_o issues a RAM read at rd_ptr;
//    rd_ptr increments. Latency 2: RAM register, then output register.
//    rd_valid_o follows 2 cycles after each accepted request.
//    rd_last_o is high with the word read at nb_word_o-1.
//    rd_req_i with rd_ptr==nb_word_o, or in any other state, is ignored (no valid).
//  Same-cycle rise and rd_req_i in DONE: the rise wins and the read is dropped.
//    Any read already in the pipe still completes.
// CONFIGURATION
//  TRACE_WRAP_EN undefined: stop-at-full behaviour as above.
//  TRACE_WRAP_EN defined: circular buffer.
//    - full_o never asserts. wr_ptr wraps DEPTH-1 -> 0.
//    - nb_word_o saturates at DEPTH. ovf_o becomes sticky "wrapped".
//    - When wrapped, readback starts at wr_ptr (oldest word) and reads DEPTH words in order.
// STRUCTURE
//  Package a_trace_pkg: AW, DEPTH, FULL_T, FLUSH, 3-bit state encoding
//    (IDLE=0, RUN=1, FLUSH=2, DONE=3), and word field offsets
//    (DATA=63:16, CNT=15:1, EQ=0). The optimiser reuses these field offsets.
//  Sub-module a_trace_ram_sdp: simple dual-port RAM, 1 write port and 1 registered
//    read port, DEPTH x 64, inferred block RAM.
// TESTING
//  T1: run rise, 3 capt_i with data 0xA..A,0xB..B,0xC..C, run fall -> nb_word_o=3.
//    3 rd_req_i give A,B,C; rd_last_o only on C.
//  T2: 8200 consecutive captures -> nb_word_o=8183 (0x1FF7), full_o=1, ovf_o=1.
//    Word 8182 reads back correctly.
//  T3: run falls, capt_i arrives 2 cycles later -> word stored (FLUSH window).
//    capt_i 6 cycles later -> ignored.
//  T4: rd_req_i during RUN -> no rd_valid_o. In DONE, 5 requests with nb_word_o=3
//    -> exactly 3 rd_valid_o.
//  T5: rst_n low mid-RUN after 10 writes -> all outputs 0 asynchronously.
//    After a new run rise, nb_word_o counts from 0.
//  T6 (TRACE_WRAP_EN): 8195 writes (value=index) -> ovf_o=1, nb_word_o=8192.
//    First read returns word 3, last read returns word 8194.

Source files
------------

// File: rtl/a_trace_pkg.sv
// a_trace_pkg: shared constants for the trace RAM write controller and the
// 48-to-64-bit optimiser (RAM geometry, stop threshold, flush length, FSM
// encoding and compressed-word field offsets).
package a_trace_pkg;

  localparam int AW      = 13;                 // RAM address width
  localparam int DEPTH   = 8192;               // RAM words
  localparam int FLUSH   = 4;                  // cycles accepted after run falls
  localparam int FLUSH_W = $clog2(FLUSH);

  // Word count at which writing stops (DEPTH-9).
  localparam logic [AW:0] FULL_T = (AW+1)'(13'h1FF7);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  // Compressed word layout: {data[47:0], repeat_cnt[14:0], eq}.
  localparam int DATA_HI = 63;
  localparam int DATA_LO = 16;
  localparam int CNT_HI  = 15;
  localparam int CNT_LO  = 1;
  localparam int EQ_BIT  = 0;

endpackage

// File: rtl/a_trace_ram_sdp.sv
// a_trace_ram_sdp: simple dual-port DEPTH x 64 RAM, one write port and one
// registered read port, written to infer block RAM.
module a_trace_ram_sdp
  import a_trace_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [63:0]   i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [63:0]   o_rd_data
);

  logic [63:0] r_mem [DEPTH];

  // Synchronous write and registered read.
  // NOTE: no reset on the array or its read register -- a reset would stop
  // the tools mapping this onto block RAM, and stale contents are harmless.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/a_trace_ram_wr_ctrl_64.sv
// a_trace_ram_wr_ctrl_64: stores optimiser words into the trace RAM during a
// verification run (plus a short flush window), stops at the almost-full
// threshold, then lets the host read the words back in write order.
// Build option: TRACE_WRAP_EN turns the store into a circular buffer that
// keeps the newest DEPTH words; ovf_o then means "wrapped".
module a_trace_ram_wr_ctrl_64
  import a_trace_pkg::*;
(
  input  logic          clk_ref,
  input  logic          rst_n,
  input  logic          run_verif_i,
  input  logic          capt_i,
  input  logic [63:0]   data_i,
  input  logic          rd_req_i,
  output logic [63:0]   rd_data_o,
  output logic          rd_valid_o,
  output logic          rd_last_o,
  output logic [AW:0]   nb_word_o,
  output logic          full_o,
  output logic          ovf_o,
  output logic          busy_o
);

  state_t               r_state, w_state_nxt;
  logic                 r_run, r_run_q;
  logic [FLUSH_W-1:0]   r_flush_cnt;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic                 r_rd_v1, r_rd_last1;
  logic                 w_rise, w_enter_run, w_in_wr, w_wr_en, w_rd_issue, w_rd_last;
  logic [AW:0]          w_nb_inc;
  logic [AW-1:0]        w_rd_addr;
  logic [63:0]          w_ram_rdata;

  assign w_rise   = r_run & ~r_run_q;
  assign w_in_wr  = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign busy_o   = w_in_wr;
  assign w_nb_inc = nb_word_o + (AW+1)'(1);

  // Register the run enable once and keep a delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_run_q <= 1'b0;
    end else begin
      r_run   <= run_verif_i;
      r_run_q <= r_run;
    end
  end

  // FSM state register and flush-window counter.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= (r_state == ST_FLUSH) ? r_flush_cnt + 1'b1 : '0;
    end
  end

  // FSM next state; flags the cycle in which a new run is entered.
  // NOTE: defaults first so no path leaves a variable unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_enter_run = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_rise) begin w_state_nxt = ST_RUN; w_enter_run = 1'b1; end
      ST_RUN:   if (!r_run) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_flush_cnt == FLUSH_W'(FLUSH - 1)) w_state_nxt = ST_DONE;
      ST_DONE:  if (w_rise) begin w_state_nxt = ST_RUN; w_enter_run = 1'b1; end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef TRACE_WRAP_EN
  assign w_wr_en   = w_in_wr & capt_i;
  // Once wrapped, the oldest word sits at the write pointer.
  assign w_rd_addr = ovf_o ? r_wr_ptr + r_rd_ptr[AW-1:0] : r_rd_ptr[AW-1:0];

  // Circular write pointer, saturating word count, sticky wrapped flag.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      nb_word_o <= '0;
      full_o    <= 1'b0;
      ovf_o     <= 1'b0;
    end else if (w_enter_run) begin
      r_wr_ptr  <= '0;
      nb_word_o <= '0;
      full_o    <= 1'b0;
      ovf_o     <= 1'b0;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (nb_word_o != (AW+1)'(DEPTH)) nb_word_o <= w_nb_inc;
      if (r_wr_ptr == AW'(DEPTH - 1))  ovf_o     <= 1'b1;
    end
  end
`else
  assign w_wr_en   = w_in_wr & capt_i & ~full_o;
  assign w_rd_addr = r_rd_ptr[AW-1:0];

  // Linear write pointer and count; full registered from the post-write
  // count; captures arriving while full set the sticky overflow flag.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      nb_word_o <= '0;
      full_o    <= 1'b0;
      ovf_o     <= 1'b0;
    end else if (w_enter_run) begin
      r_wr_ptr  <= '0;
      nb_word_o <= '0;
      full_o    <= 1'b0;
      ovf_o     <= 1'b0;
    end else if (w_wr_en) begin
      r_wr_ptr  <= r_wr_ptr + 1'b1;
      nb_word_o <= w_nb_inc;
      full_o    <= (w_nb_inc == FULL_T);
    end else if (w_in_wr && capt_i) begin
      ovf_o <= 1'b1;
    end
  end
`endif

  // A new run edge in DONE takes priority over a read in the same cycle.
  assign w_rd_issue = (r_state == ST_DONE) && !w_rise && rd_req_i && (r_rd_ptr < nb_word_o);
  assign w_rd_last  = (r_rd_ptr == nb_word_o - (AW+1)'(1));

  // Read pointer and first pipeline stage (aligned with the RAM register).
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_rd_v1    <= 1'b0;
      r_rd_last1 <= 1'b0;
    end else begin
      r_rd_v1    <= w_rd_issue;
      r_rd_last1 <= w_rd_issue & w_rd_last;
      if (w_enter_run)     r_rd_ptr <= '0;
      else if (w_rd_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Output register stage: second cycle of read latency.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      rd_last_o  <= 1'b0;
    end else begin
      rd_valid_o <= r_rd_v1;
      rd_last_o  <= r_rd_last1;
      if (r_rd_v1) rd_data_o <= w_ram_rdata;
    end
  end

  a_trace_ram_sdp u_ram (
    .i_clk     (clk_ref),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_i),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_rdata)
  );

endmodule

// File: tb/tb_a_trace_ram_wr_ctrl_64.sv
// tb_a_trace_ram_wr_ctrl_64: directed self-checking bench for the trace RAM
// write controller. Build with TRACE_WRAP_EN to exercise the circular mode.
module tb_a_trace_ram_wr_ctrl_64;
  import a_trace_pkg::*;

  logic          clk_ref = 1'b0;
  logic          rst_n, run_verif_i, capt_i, rd_req_i;
  logic [63:0]   data_i;
  logic [63:0]   rd_data_o;
  logic          rd_valid_o, rd_last_o, full_o, ovf_o, busy_o;
  logic [AW:0]   nb_word_o;

  int n_checks = 0;
  int n_errors = 0;

  a_trace_ram_wr_ctrl_64 dut (
    .clk_ref     (clk_ref),
    .rst_n       (rst_n),
    .run_verif_i (run_verif_i),
    .capt_i      (capt_i),
    .data_i      (data_i),
    .rd_req_i    (rd_req_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .rd_last_o   (rd_last_o),
    .nb_word_o   (nb_word_o),
    .full_o      (full_o),
    .ovf_o       (ovf_o),
    .busy_o      (busy_o)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic run_start();
    run_verif_i = 1'b1;
    tick();
    tick();
  endtask

  // Drop the run enable and wait (bounded) for the FSM to leave RUN/FLUSH.
  task automatic run_stop(input string tag);
    int n;
    run_verif_i = 1'b0;
    n = 0;
    tick();
    while (busy_o && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_done_timeout"}, 64'(busy_o), 64'd0);
  endtask

  task automatic capture(input logic [63:0] d);
    capt_i = 1'b1;
    data_i = d;
    tick();
    capt_i = 1'b0;
  endtask

  // Single read request; the word is visible two edges after the request.
  task automatic read_one(output logic [63:0] d, output logic v, output logic l);
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    tick();
    d = rd_data_o;
    v = rd_valid_o;
    l = rd_last_o;
  endtask

  task automatic read_check(input string tag, input logic [63:0] exp_d, input logic exp_l);
    logic [63:0] d;
    logic v, l;
    read_one(d, v, l);
    check({tag, "_valid"}, 64'(v), 64'd1);
    check({tag, "_data"}, d, exp_d);
    check({tag, "_last"}, 64'(l), 64'(exp_l));
  endtask

  initial begin
    logic [63:0] d;
    logic v, l;
    int nv, nl, bad;

    rst_n = 1'b0; run_verif_i = 1'b0; capt_i = 1'b0; rd_req_i = 1'b0; data_i = '0;
    repeat (3) tick();
    check("rst_nb", 64'(nb_word_o), 64'd0);
    check("rst_flags", {60'd0, full_o, ovf_o, busy_o, rd_valid_o}, 64'd0);
    check("rst_rd_data", rd_data_o, 64'd0);
    #2 rst_n = 1'b1;
    tick();

    // T1: three words, read back in order, last flag only on the third.
    run_start();
    check("t1_busy", 64'(busy_o), 64'd1);
    capture({16{4'hA}});
    capture({16{4'hB}});
    capture({16{4'hC}});
    check("t1_nb", 64'(nb_word_o), 64'd3);
    run_stop("t1");
    read_check("t1_rd0", {16{4'hA}}, 1'b0);
    read_check("t1_rd1", {16{4'hB}}, 1'b0);
    read_check("t1_rd2", {16{4'hC}}, 1'b1);
    read_one(d, v, l);
    check("t1_rd_past_end", 64'(v), 64'd0);

`ifndef TRACE_WRAP_EN
    // T2: 8200 back-to-back captures stop at FULL_T words with overflow.
    run_start();
    check("t2_clear_nb", 64'(nb_word_o), 64'd0);
    capt_i = 1'b1;
    for (int i = 0; i < 8200; i++) begin
      data_i = {32'hD00D_0000, 32'(i)};
      tick();
      if (i == 8181) check("t2_full_before", 64'(full_o), 64'd0);
      if (i == 8182) check("t2_full_at", 64'(full_o), 64'd1);
      if (i == 8182) check("t2_ovf_at", 64'(ovf_o), 64'd0);
    end
    capt_i = 1'b0;
    check("t2_nb", 64'(nb_word_o), 64'h1FF7);
    check("t2_full", 64'(full_o), 64'd1);
    check("t2_ovf", 64'(ovf_o), 64'd1);
    run_stop("t2");
    bad = 0;
    for (int i = 0; i < 8182; i++) begin
      read_one(d, v, l);
      if (!v || l || d !== {32'hD00D_0000, 32'(i)}) bad++;
    end
    check("t2_bulk_bad", 64'(bad), 64'd0);
    read_check("t2_rd8182", {32'hD00D_0000, 32'd8182}, 1'b1);
`endif

    // T3: flush window accepts a capture 2 edges after the fall, not 6.
    run_start();
    capture(64'h1111);
    run_verif_i = 1'b0;
    tick();
    tick();
    capture(64'h3333);
    repeat (3) tick();
    check("t3_busy_end", 64'(busy_o), 64'd0);
    capture(64'h6666);
    check("t3_nb", 64'(nb_word_o), 64'd2);
    check("t3_ovf", 64'(ovf_o), 64'd0);
    read_check("t3_rd0", 64'h1111, 1'b0);
    read_check("t3_rd1", 64'h3333, 1'b1);

    // T4: reads ignored in RUN; five requests for three words yield three.
    run_start();
    capture(64'h4400);
    capture(64'h4401);
    capture(64'h4402);
    nv = 0;
    rd_req_i = 1'b1;
    repeat (4) begin tick(); nv += int'(rd_valid_o); end
    rd_req_i = 1'b0;
    repeat (2) begin tick(); nv += int'(rd_valid_o); end
    check("t4_run_no_valid", 64'(nv), 64'd0);
    run_stop("t4");
    nv = 0; nl = 0;
    rd_req_i = 1'b1;
    repeat (5) begin tick(); nv += int'(rd_valid_o); nl += int'(rd_last_o); end
    rd_req_i = 1'b0;
    repeat (3) begin tick(); nv += int'(rd_valid_o); nl += int'(rd_last_o); end
    check("t4_valid_cnt", 64'(nv), 64'd3);
    check("t4_last_cnt", 64'(nl), 64'd1);
    check("t4_last_data", rd_data_o, 64'h4402);

    // T5: asynchronous reset mid-run clears outputs without a clock edge.
    run_start();
    for (int i = 0; i < 10; i++) capture(64'(i));
    check("t5_nb_pre", 64'(nb_word_o), 64'd10);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_nb", 64'(nb_word_o), 64'd0);
    check("t5_async_flags", {60'd0, full_o, ovf_o, busy_o, rd_valid_o}, 64'd0);
    check("t5_async_data", rd_data_o, 64'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("t5_idle_busy", 64'(busy_o), 64'd0);
    run_start();
    check("t5_new_nb", 64'(nb_word_o), 64'd0);
    capture(64'h55);
    check("t5_new_nb1", 64'(nb_word_o), 64'd1);
    run_stop("t5");
    read_check("t5_rd0", 64'h55, 1'b1);

`ifdef TRACE_WRAP_EN
    // T6: 8195 writes wrap; readback is the newest DEPTH words, oldest first.
    run_start();
    capt_i = 1'b1;
    for (int i = 0; i < 8195; i++) begin
      data_i = 64'(i);
      tick();
    end
    capt_i = 1'b0;
    check("t6_ovf", 64'(ovf_o), 64'd1);
    check("t6_nb", 64'(nb_word_o), 64'd8192);
    check("t6_full", 64'(full_o), 64'd0);
    run_stop("t6");
    read_check("t6_rd_first", 64'd3, 1'b0);
    bad = 0;
    for (int i = 1; i < 8191; i++) begin
      read_one(d, v, l);
      if (!v || l || d !== 64'(i + 3)) bad++;
    end
    check("t6_bulk_bad", 64'(bad), 64'd0);
    read_check("t6_rd_last", 64'd8194, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
